// File: rtl/exu_seq_ctrl_pkg.sv
// Shared types and constants for the execution sequencer.
// The state encoding is fixed at 3 bits so it can be probed directly from a debug bus.
package exu_seq_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MEM_REQ    = 3'd3,
    MEM_WAIT   = 3'd4,
    WB         = 3'd5,
    HALT       = 3'd6,
    TRAP       = 3'd7
  } state_t;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam int          INST_BYTES       = 4;
  localparam logic [1:0]  MISALIGN_MASK    = 2'b11;

endpackage

// File: rtl/exu_seq_ctrl_if.sv
// Instruction and data memory handshake bundle between the sequencer (master) and the memory side (slave).
interface exu_seq_ctrl_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_rsp_valid;

  modport master (
    output imem_req_valid, imem_addr, dmem_req_valid,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dmem_req_ready, dmem_rsp_valid
  );

  modport slave (
    input  imem_req_valid, imem_addr, dmem_req_valid,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dmem_req_ready, dmem_rsp_valid
  );

endinterface

// File: rtl/exu_seq_ctrl_perf.sv
// Cycle and retired-instruction counters; only present when EXU_SEQ_PERF_CNT_EN is defined.
// Both counters wrap silently.
`ifdef EXU_SEQ_PERF_CNT_EN
module exu_seq_perf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cycle_en,
  input  logic         retire,
  output logic [W-1:0] cycle_cnt,
  output logic [W-1:0] instret_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cycle_en) cycle_cnt <= cycle_cnt + W'(1);
      if (retire)   instret_cnt <= instret_cnt + W'(1);
    end
  end

endmodule
`endif

// File: rtl/exu_seq_ctrl.sv
// Multi-cycle sequencer: fetch, execute, optional memory access, writeback; sticky halt/trap.
// Optional perf counters (cycle_cnt, instret_cnt) are built when EXU_SEQ_PERF_CNT_EN is defined.
module exu_seq_ctrl
  import exu_seq_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              ILEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  exu_seq_ctrl_if.master  mem,
  output logic [ILEN-1:0] inst,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_jump,
  input  logic            dec_ebreak,
  input  logic            dec_invalid,
  input  logic [XLEN-1:0] dnpc,
  output logic [XLEN-1:0] pc,
  output logic            rf_we,
  output logic            retire,
  output logic            halted,
  output logic            trap
`ifdef EXU_SEQ_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] inst_q;
  logic            jump_misalign;
  logic            wb_commit;

  assign jump_misalign = dec_jump && ((dnpc[1:0] & MISALIGN_MASK) != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH_REQ;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_REQ:  if (mem.imem_req_ready) state_nxt = FETCH_WAIT;
      FETCH_WAIT: if (mem.imem_rsp_valid) state_nxt = EXEC;
      EXEC: begin
        if (dec_invalid)                 state_nxt = TRAP;
        else if (dec_ebreak)             state_nxt = HALT;
        else if (dec_load || dec_store)  state_nxt = MEM_REQ;
        else                             state_nxt = WB;
      end
      MEM_REQ:    if (mem.dmem_req_ready) state_nxt = MEM_WAIT;
      MEM_WAIT:   if (mem.dmem_rsp_valid) state_nxt = WB;
      WB:         state_nxt = jump_misalign ? TRAP : FETCH_REQ;
      HALT:       state_nxt = HALT;
      TRAP:       state_nxt = TRAP;
    endcase
  end

  // The fetch request is gated by rst so it drops the moment reset asserts.
  always_comb begin
    mem.imem_req_valid = (state == FETCH_REQ) && rst;
    mem.dmem_req_valid = (state == MEM_REQ);
    wb_commit          = (state == WB) && !jump_misalign;
    rf_we              = wb_commit && !dec_store;
    retire             = wb_commit || ((state == EXEC) && !dec_invalid && dec_ebreak);
    halted             = (state == HALT);
    trap               = (state == TRAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      inst_q <= '0;
    end else begin
      if ((state == FETCH_WAIT) && mem.imem_rsp_valid) inst_q <= mem.imem_rsp_data;
      if (wb_commit) pc_q <= dec_jump ? dnpc : pc_q + XLEN'(INST_BYTES);
    end
  end

  assign pc            = pc_q;
  assign inst          = inst_q;
  assign mem.imem_addr = pc_q;

`ifdef EXU_SEQ_PERF_CNT_EN
  exu_seq_perf #(.W(64)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .cycle_en    (!(halted || trap)),
    .retire      (retire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif

endmodule
